caida_objetos_multi: RTL and testbench
======================================

Name: caida_objetos_multi

Overview:
- Parametrised successor of the single falling-cube block.
- Manages N_OBJ independent falling objects, each in its own slot, and allocates a free slot on each spawn request.
- Per frame: advances every object, detects basket catches and floor misses, and keeps a saturating score.
- Sits between the game controller (spawn requests, random X/colour/speed) and the VGA pixel mux (paint flag and colour).

Parameters:
- N_OBJ, 4, number of object slots (1..8).
- OBJ_SIZE, 60, object edge in pixels.
- MAX_X, 640, screen width.
- MAX_Y, 480, screen height; object is missed when bottom y >= MAX_Y.
- CANASTA_W, 80, basket width in pixels.
- VEL_W, 2, velocity field width.
- SCORE_W, 16, score accumulator width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pixel_x  in  10  current scan X.
- pixel_y  in  10  current scan Y.
- spawn  in  1  one-cycle spawn request.
- spawn_x  in  10  initial X of the new object.
- spawn_vel  in  VEL_W  pixels per frame.
- spawn_color  in  8  object colour.
- pos_x_canasta  in  10  basket left X.
- pos_y_canasta  in  9  basket top Y.
- spawn_ack  out  1  pulse: request accepted.
- spawn_drop  out  1  pulse: request rejected (all slots busy).
- pintar_obj  out  1  current pixel is inside any active object.
- color_obj  out  8  colour of the lowest-index active object covering the pixel; 0 when none.
- captura  out  1  pulse: one or more catches this frame.
- perdido  out  1  pulse: one or more misses this frame.
- puntos  out  SCORE_W  accumulated score.
- ocupados  out  N_OBJ  per-slot active flags.

Behaviour:
- Reset: all slots IDLE; slot x/y/vel/colour = 0; every output 0.
- Reset mid-flight discards all objects and the score on the same edge.
- Frame tick: `tick = (pixel_y == 481) && (pixel_x == 0)`, registered internally; all slot updates use it.
- Per-slot FSM: IDLE -> FALLING -> {CAUGHT, MISSED} -> IDLE.
- CAUGHT and MISSED last exactly one cycle.
- Spawn:
  - On a `spawn` cycle, the lowest-index IDLE slot loads x = spawn_x, y = 0, vel = spawn_vel, colour = spawn_color.
  - spawn_vel == 0 is stored as 1.
  - spawn_x > MAX_X-OBJ_SIZE is clamped to MAX_X-OBJ_SIZE.
  - spawn_ack is high the next cycle.
  - If no slot is IDLE, spawn_drop is high the next cycle and no state changes.
  - A slot returning to IDLE in the same cycle is not yet free.
- FALLING, on tick, evaluated in this order:
  - Catch if y > pos_y_canasta, x >= pos_x_canasta and x+OBJ_SIZE <= pos_x_canasta+CANASTA_W-1 -> CAUGHT.
  - Else miss if y+vel >= MAX_Y -> MISSED.
  - Else y <= y+vel, computed 10-bit with no wrap.
  - Catch has priority over miss on the same tick.
- CAUGHT: puntos += vel.
  - Several slots caught on one tick add the sum of their velocities in a single update.
  - puntos saturates at all-ones; it never wraps.
- captura / perdido: one-cycle pulses, one cycle after the tick, OR-reduced across slots.
- Paint: slot i covers the pixel when FALLING and x <= pixel_x <= x+OBJ_SIZE and ymin <= pixel_y <= y.
  - ymin = 0 if y < OBJ_SIZE, else y-OBJ_SIZE (no underflow).
  - pintar_obj and color_obj are registered: one-cycle latency from pixel_x/pixel_y.
  - Overlap: the lowest index wins color_obj.
- ocupados[i] is 1 in FALLING, CAUGHT and MISSED.
- Spawn on a tick cycle: the new slot starts at y = 0 and does not move on that tick.

Optional Feature:
- PAUSA_EN: when defined, adds input port `pausa` (1 bit).
  - While pausa = 1, ticks are ignored: no movement, catch or miss.
  - Spawns are still accepted; paint stays active.
- Without PAUSA_EN: no port; every tick is processed.

Test Plan:
- Reset, spawn x=100 vel=2 color=8'hE0 -> spawn_ack next cycle; ocupados=0001; after 10 ticks y=20; pintar_obj=1 at (100,10), 0 at (161,10).
- Four spawns, then a fifth -> ocupados=1111; fifth gives spawn_drop=1, spawn_ack=0; lowest slot freed by a miss accepts the next spawn.
- Basket x=90, y=400; object x=100 vel=3 -> after y passes 400, next tick gives captura=1 and puntos=3; slot IDLE two cycles later.
- Object x=0 vel=3, basket far away -> at y=477 the next tick gives perdido=1, puntos unchanged, y never exceeds 480.
- Two objects caught on the same tick (vel 2 and 3) with puntos=16'hFFFD -> puntos=16'hFFFF, saturated.
- PAUSA_EN build: pausa=1 for 5 ticks -> y unchanged; pausa=0 -> movement resumes. Reset asserted mid-flight -> all outputs 0 next cycle.

Source files
------------

// File: rtl/caida_objetos_multi.sv
// caida_objetos_multi
//   Multi-slot falling-object engine. Each of N_OBJ slots holds one object
//   that falls once per frame; a spawn request claims the lowest free slot.
//   Catches in the basket add the object's velocity to a saturating score,
//   and objects that reach the floor are dropped.
//
// Optional build macro: PAUSA_EN adds input `pausa`, which freezes frame
// processing (no movement, catch or miss) while spawns and paint keep working.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pixel_x, pixel_y           current VGA scan position
//   spawn, spawn_x, spawn_vel,
//   spawn_color                spawn request and new object attributes
//   pos_x_canasta, pos_y_canasta  basket left X / top Y
//   pausa (PAUSA_EN only)      freeze frame ticks
//   spawn_ack, spawn_drop      request accepted / rejected (registered pulses)
//   pintar_obj, color_obj      paint flag and colour, one cycle behind pixel
//   captura, perdido           catch / miss pulses
//   puntos                     saturating score
//   ocupados                   per-slot busy flags
module caida_objetos_multi #(
  parameter int unsigned N_OBJ     = 4,
  parameter int unsigned OBJ_SIZE  = 60,
  parameter int unsigned MAX_X     = 640,
  parameter int unsigned MAX_Y     = 480,
  parameter int unsigned CANASTA_W = 80,
  parameter int unsigned VEL_W     = 2,
  parameter int unsigned SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               spawn,
  input  logic [9:0]         spawn_x,
  input  logic [VEL_W-1:0]   spawn_vel,
  input  logic [7:0]         spawn_color,
  input  logic [9:0]         pos_x_canasta,
  input  logic [8:0]         pos_y_canasta,
`ifdef PAUSA_EN
  input  logic               pausa,
`endif
  output logic               spawn_ack,
  output logic               spawn_drop,
  output logic               pintar_obj,
  output logic [7:0]         color_obj,
  output logic               captura,
  output logic               perdido,
  output logic [SCORE_W-1:0] puntos,
  output logic [N_OBJ-1:0]   ocupados
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FALLING = 2'd1,
    S_CAUGHT  = 2'd2,
    S_MISSED  = 2'd3
  } state_t;

  // 12-bit working width keeps x+size and basket-right sums from wrapping
  localparam int unsigned  C_W     = 12;
  localparam int unsigned  SUM_W   = SCORE_W + VEL_W + 4;
  localparam logic [9:0]   X_LIM   = 10'(MAX_X - OBJ_SIZE);
  localparam logic [9:0]   SIZE_10 = 10'(OBJ_SIZE);
  localparam logic [C_W-1:0] SIZE_C = C_W'(OBJ_SIZE);
  localparam logic [C_W-1:0] MAXY_C = C_W'(MAX_Y);
  localparam logic [C_W-1:0] CANW_C = C_W'(CANASTA_W - 1);

  state_t             r_state [N_OBJ];
  logic [9:0]         r_x     [N_OBJ];
  logic [9:0]         r_y     [N_OBJ];
  logic [VEL_W-1:0]   r_vel   [N_OBJ];
  logic [7:0]         r_color [N_OBJ];
  logic               r_tick;
  logic               r_spawn_ack;
  logic               r_spawn_drop;
  logic               r_pintar;
  logic [7:0]         r_color_obj;
  logic               r_captura;
  logic               r_perdido;
  logic [SCORE_W-1:0] r_puntos;
  logic [N_OBJ-1:0]   r_ocupados;

  logic               w_tick;
  logic               w_go;
  logic [9:0]         w_spawn_x;
  logic [VEL_W-1:0]   w_spawn_vel;
  logic [9:0]         w_y_next [N_OBJ];
  logic [9:0]         w_ymin   [N_OBJ];
  logic [N_OBJ-1:0]   w_hit;
  logic [N_OBJ-1:0]   w_catch;
  logic [N_OBJ-1:0]   w_miss;
  logic [N_OBJ-1:0]   w_cover;
  logic [N_OBJ-1:0]   w_free_sel;
  logic               w_free_found;
  logic               w_pintar;
  logic [7:0]         w_color;
  logic [SUM_W-1:0]   w_sum;
  logic [SUM_W-1:0]   w_total;
  logic [SCORE_W-1:0] w_puntos_next;

  // Frame tick: first pixel of line 481, registered before use
  assign w_tick = (pixel_y == 10'd481) && (pixel_x == 10'd0);

`ifdef PAUSA_EN
  assign w_go = r_tick && !pausa;
`else
  assign w_go = r_tick;
`endif

  // Spawn attribute sanitising: keep object on screen, never a stalled object
  assign w_spawn_x   = (spawn_x > X_LIM) ? X_LIM : spawn_x;
  assign w_spawn_vel = (spawn_vel == '0) ? VEL_W'(1) : spawn_vel;

  // Per-slot movement, catch/miss and coverage evaluation
  always_comb begin : slot_eval
    for (int i = 0; i < N_OBJ; i++) begin
      w_y_next[i] = r_y[i] + 10'(r_vel[i]);
      w_ymin[i]   = (r_y[i] < SIZE_10) ? 10'd0 : r_y[i] - SIZE_10;
      w_hit[i]    = (r_y[i] > {1'b0, pos_y_canasta}) &&
                    (r_x[i] >= pos_x_canasta) &&
                    (C_W'(r_x[i]) + SIZE_C <= C_W'(pos_x_canasta) + CANW_C);
      w_catch[i]  = w_go && (r_state[i] == S_FALLING) && w_hit[i];
      w_miss[i]   = w_go && (r_state[i] == S_FALLING) && !w_hit[i] &&
                    (C_W'(r_y[i]) + C_W'(r_vel[i]) >= MAXY_C);
      w_cover[i]  = (r_state[i] == S_FALLING) &&
                    (pixel_x >= r_x[i]) &&
                    (C_W'(pixel_x) <= C_W'(r_x[i]) + SIZE_C) &&
                    (pixel_y >= w_ymin[i]) && (pixel_y <= r_y[i]);
    end
  end

  // Lowest-index selection for free slot and paint colour; caught-velocity sum
  always_comb begin : priority_pick
    w_free_sel   = '0;
    w_free_found = 1'b0;
    w_pintar     = 1'b0;
    w_color      = 8'd0;
    w_sum        = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!w_free_found && (r_state[i] == S_IDLE)) begin
        w_free_sel[i] = 1'b1;
        w_free_found  = 1'b1;
      end
      if (!w_pintar && w_cover[i]) begin
        w_pintar = 1'b1;
        w_color  = r_color[i];
      end
      if (w_catch[i]) begin
        w_sum = w_sum + SUM_W'(r_vel[i]);
      end
    end
    w_total       = SUM_W'(r_puntos) + w_sum;
    w_puntos_next = (w_total > SUM_W'({SCORE_W{1'b1}})) ? '1 : w_total[SCORE_W-1:0];
  end

  // Slot FSMs and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick       <= 1'b0;
      r_spawn_ack  <= 1'b0;
      r_spawn_drop <= 1'b0;
      r_pintar     <= 1'b0;
      r_color_obj  <= 8'd0;
      r_captura    <= 1'b0;
      r_perdido    <= 1'b0;
      r_puntos     <= '0;
      r_ocupados   <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        r_state[i] <= S_IDLE;
        r_x[i]     <= '0;
        r_y[i]     <= '0;
        r_vel[i]   <= '0;
        r_color[i] <= '0;
      end
    end else begin
      r_tick       <= w_tick;
      r_spawn_ack  <= spawn && w_free_found;
      r_spawn_drop <= spawn && !w_free_found;
      r_pintar     <= w_pintar;
      r_color_obj  <= w_color;
      r_captura    <= |w_catch;
      r_perdido    <= |w_miss;
      if (|w_catch) begin
        r_puntos <= w_puntos_next;
      end
      for (int i = 0; i < N_OBJ; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (spawn && w_free_sel[i]) begin
              r_state[i]    <= S_FALLING;
              r_x[i]        <= w_spawn_x;
              r_y[i]        <= 10'd0;
              r_vel[i]      <= w_spawn_vel;
              r_color[i]    <= spawn_color;
              r_ocupados[i] <= 1'b1;
            end
          end
          S_FALLING: begin
            // catch is checked before miss, so it wins on the same tick
            if (w_catch[i]) begin
              r_state[i] <= S_CAUGHT;
            end else if (w_miss[i]) begin
              r_state[i] <= S_MISSED;
            end else if (w_go) begin
              r_y[i] <= w_y_next[i];
            end
          end
          S_CAUGHT, S_MISSED: begin
            r_state[i]    <= S_IDLE;
            r_ocupados[i] <= 1'b0;
          end
          default: begin
            r_state[i] <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign spawn_ack  = r_spawn_ack;
  assign spawn_drop = r_spawn_drop;
  assign pintar_obj = r_pintar;
  assign color_obj  = r_color_obj;
  assign captura    = r_captura;
  assign perdido    = r_perdido;
  assign puntos     = r_puntos;
  assign ocupados   = r_ocupados;

endmodule

// File: tb/tb_caida_objetos_multi.sv
// Directed bench for caida_objetos_multi: a default instance plus a 4-bit
// score instance sharing the same stimulus, for score saturation.
module tb_caida_objetos_multi;

  logic       clk;
  logic       reset;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       spawn;
  logic [9:0] spawn_x;
  logic [1:0] spawn_vel;
  logic [7:0] spawn_color;
  logic [9:0] pos_x_canasta;
  logic [8:0] pos_y_canasta;
`ifdef PAUSA_EN
  logic       pausa;
`endif

  logic        spawn_ack, spawn_drop, pintar_obj, captura, perdido;
  logic [7:0]  color_obj;
  logic [15:0] puntos;
  logic [3:0]  ocupados;

  logic        s_spawn_ack, s_spawn_drop, s_pintar_obj, s_captura, s_perdido;
  logic [7:0]  s_color_obj;
  logic [3:0]  s_puntos;
  logic [3:0]  s_ocupados;

  int checks;
  int failures;

  caida_objetos_multi dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .spawn(spawn), .spawn_x(spawn_x), .spawn_vel(spawn_vel), .spawn_color(spawn_color),
    .pos_x_canasta(pos_x_canasta), .pos_y_canasta(pos_y_canasta),
`ifdef PAUSA_EN
    .pausa(pausa),
`endif
    .spawn_ack(spawn_ack), .spawn_drop(spawn_drop), .pintar_obj(pintar_obj),
    .color_obj(color_obj), .captura(captura), .perdido(perdido),
    .puntos(puntos), .ocupados(ocupados)
  );

  caida_objetos_multi #(.SCORE_W(4)) dut_s (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .spawn(spawn), .spawn_x(spawn_x), .spawn_vel(spawn_vel), .spawn_color(spawn_color),
    .pos_x_canasta(pos_x_canasta), .pos_y_canasta(pos_y_canasta),
`ifdef PAUSA_EN
    .pausa(pausa),
`endif
    .spawn_ack(s_spawn_ack), .spawn_drop(s_spawn_drop), .pintar_obj(s_pintar_obj),
    .color_obj(s_color_obj), .captura(s_captura), .perdido(s_perdido),
    .puntos(s_puntos), .ocupados(s_ocupados)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spawn = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic do_spawn(input logic [9:0] x, input logic [1:0] v, input logic [7:0] c);
    spawn = 1'b1; spawn_x = x; spawn_vel = v; spawn_color = c;
    step();
    spawn = 1'b0;
  endtask

  // Tick pixel for one cycle, then one more cycle for the slot update
  task automatic do_tick();
    pixel_x = 10'd0; pixel_y = 10'd481;
    step();
    pixel_x = 10'd700; pixel_y = 10'd0;
    step();
  endtask

  task automatic probe(input logic [9:0] px, input logic [9:0] py);
    pixel_x = px; pixel_y = py;
    step();
    pixel_x = 10'd700; pixel_y = 10'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; spawn = 1'b1; spawn_x = 10'd100; spawn_vel = 2'd1;
    pixel_x = 10'd0; pixel_y = 10'd481;
    step(); step();
    checks++; if ({spawn_ack, spawn_drop, pintar_obj, captura, perdido} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {spawn_ack, spawn_drop, pintar_obj, captura, perdido}); end
    checks++; if ({color_obj, puntos, ocupados} !== 28'h0) begin failures++; $display("FAIL rst_values got=%h exp=0", {color_obj, puntos, ocupados}); end
    checks++; if ({s_spawn_ack, s_spawn_drop, s_puntos, s_ocupados} !== 10'h0) begin failures++; $display("FAIL rst_small got=%h exp=0", {s_spawn_ack, s_spawn_drop, s_puntos, s_ocupados}); end
    reset = 1'b0; spawn = 1'b0;
    pixel_x = 10'd700; pixel_y = 10'd0;
    step();
  endtask

  task automatic test_basic();
    pos_x_canasta = 10'd1000; pos_y_canasta = 9'd0;
    do_reset();
    do_spawn(10'd100, 2'd2, 8'hE0);
    checks++; if (spawn_ack !== 1'b1 || spawn_drop !== 1'b0) begin failures++; $display("FAIL basic_ack got=%b%b exp=10", spawn_ack, spawn_drop); end
    checks++; if (ocupados !== 4'b0001) begin failures++; $display("FAIL basic_ocup got=%b exp=0001", ocupados); end
    step();
    checks++; if (spawn_ack !== 1'b0) begin failures++; $display("FAIL basic_ack_pulse got=%b exp=0", spawn_ack); end
    for (int k = 0; k < 10; k++) do_tick();
    probe(10'd100, 10'd10);
    checks++; if (pintar_obj !== 1'b1 || color_obj !== 8'hE0) begin failures++; $display("FAIL basic_paint_in got=%b/%h exp=1/e0", pintar_obj, color_obj); end
    probe(10'd160, 10'd10);
    checks++; if (pintar_obj !== 1'b1) begin failures++; $display("FAIL basic_paint_right got=%b exp=1", pintar_obj); end
    probe(10'd161, 10'd10);
    checks++; if (pintar_obj !== 1'b0 || color_obj !== 8'h00) begin failures++; $display("FAIL basic_paint_out got=%b/%h exp=0/00", pintar_obj, color_obj); end
    probe(10'd99, 10'd10);
    checks++; if (pintar_obj !== 1'b0) begin failures++; $display("FAIL basic_paint_left got=%b exp=0", pintar_obj); end
    probe(10'd100, 10'd20);
    checks++; if (pintar_obj !== 1'b1) begin failures++; $display("FAIL basic_y20 got=%b exp=1", pintar_obj); end
    probe(10'd100, 10'd21);
    checks++; if (pintar_obj !== 1'b0) begin failures++; $display("FAIL basic_y21 got=%b exp=0", pintar_obj); end
    checks++; if (captura !== 1'b0 || perdido !== 1'b0 || puntos !== 16'd0) begin failures++; $display("FAIL basic_quiet got=%b%b/%0d exp=00/0", captura, perdido, puntos); end
  endtask

  task automatic test_clamp();
    pos_x_canasta = 10'd1000; pos_y_canasta = 9'd0;
    do_reset();
    do_spawn(10'd1000, 2'd0, 8'h33);
    checks++; if (spawn_ack !== 1'b1) begin failures++; $display("FAIL clamp_ack got=%b exp=1", spawn_ack); end
    probe(10'd580, 10'd0);
    checks++; if (pintar_obj !== 1'b1 || color_obj !== 8'h33) begin failures++; $display("FAIL clamp_580 got=%b/%h exp=1/33", pintar_obj, color_obj); end
    probe(10'd579, 10'd0);
    checks++; if (pintar_obj !== 1'b0) begin failures++; $display("FAIL clamp_579 got=%b exp=0", pintar_obj); end
    probe(10'd640, 10'd0);
    checks++; if (pintar_obj !== 1'b1) begin failures++; $display("FAIL clamp_640 got=%b exp=1", pintar_obj); end
    do_tick();
    probe(10'd580, 10'd1);
    checks++; if (pintar_obj !== 1'b1) begin failures++; $display("FAIL vel0_y1 got=%b exp=1", pintar_obj); end
    probe(10'd580, 10'd2);
    checks++; if (pintar_obj !== 1'b0) begin failures++; $display("FAIL vel0_y2 got=%b exp=0", pintar_obj); end
  endtask

  task automatic test_full_and_miss();
    pos_x_canasta = 10'd1000; pos_y_canasta = 9'd0;
    do_reset();
    do_spawn(10'd0,   2'd3, 8'h11);
    do_spawn(10'd200, 2'd1, 8'h22);
    do_spawn(10'd300, 2'd1, 8'h33);
    do_spawn(10'd400, 2'd1, 8'h44);
    checks++; if (ocupados !== 4'b1111 || spawn_ack !== 1'b1) begin failures++; $display("FAIL full_ocup got=%b ack=%b exp=1111 ack=1", ocupados, spawn_ack); end
    do_spawn(10'd500, 2'd1, 8'h55);
    checks++; if (spawn_drop !== 1'b1 || spawn_ack !== 1'b0) begin failures++; $display("FAIL full_drop got=%b%b exp=10", spawn_drop, spawn_ack); end
    checks++; if (ocupados !== 4'b1111) begin failures++; $display("FAIL full_ocup2 got=%b exp=1111", ocupados); end
    for (int k = 0; k < 159; k++) do_tick();
    probe(10'd0, 10'd477);
    checks++; if (pintar_obj !== 1'b1 || color_obj !== 8'h11) begin failures++; $display("FAIL miss_y477 got=%b/%h exp=1/11", pintar_obj, color_obj); end
    probe(10'd0, 10'd478);
    checks++; if (pintar_obj !== 1'b0) begin failures++; $display("FAIL miss_y478 got=%b exp=0", pintar_obj); end
    checks++; if (perdido !== 1'b0) begin failures++; $display("FAIL miss_early got=%b exp=0", perdido); end
    do_tick();
    checks++; if (perdido !== 1'b1 || captura !== 1'b0) begin failures++; $display("FAIL miss_pulse got=%b%b exp=10", perdido, captura); end
    checks++; if (puntos !== 16'd0 || ocupados !== 4'b1111) begin failures++; $display("FAIL miss_state got=%0d/%b exp=0/1111", puntos, ocupados); end
    // slot 0 is MISSED this cycle: not yet free
    do_spawn(10'd500, 2'd2, 8'h66);
    checks++; if (spawn_drop !== 1'b1 || spawn_ack !== 1'b0) begin failures++; $display("FAIL miss_notfree got=%b%b exp=10", spawn_drop, spawn_ack); end
    checks++; if (ocupados !== 4'b1110 || perdido !== 1'b0) begin failures++; $display("FAIL miss_idle got=%b/%b exp=1110/0", ocupados, perdido); end
    do_spawn(10'd500, 2'd2, 8'h66);
    checks++; if (spawn_ack !== 1'b1 || ocupados !== 4'b1111) begin failures++; $display("FAIL reuse got=%b/%b exp=1/1111", spawn_ack, ocupados); end
    probe(10'd500, 10'd0);
    checks++; if (pintar_obj !== 1'b1 || color_obj !== 8'h66) begin failures++; $display("FAIL reuse_paint got=%b/%h exp=1/66", pintar_obj, color_obj); end
  endtask

  task automatic test_catch();
    pos_x_canasta = 10'd90; pos_y_canasta = 9'd400;
    do_reset();
    do_spawn(10'd100, 2'd3, 8'h1C);
    for (int k = 0; k < 134; k++) do_tick();
    checks++; if (captura !== 1'b0 || puntos !== 16'd0) begin failures++; $display("FAIL catch_early got=%b/%0d exp=0/0", captura, puntos); end
    probe(10'd100, 10'd402);
    checks++; if (pintar_obj !== 1'b1) begin failures++; $display("FAIL catch_y402 got=%b exp=1", pintar_obj); end
    do_tick();
    checks++; if (captura !== 1'b1 || perdido !== 1'b0 || puntos !== 16'd3) begin failures++; $display("FAIL catch_pulse got=%b%b/%0d exp=10/3", captura, perdido, puntos); end
    checks++; if (ocupados !== 4'b0001) begin failures++; $display("FAIL catch_busy got=%b exp=0001", ocupados); end
    step();
    checks++; if (captura !== 1'b0 || ocupados !== 4'b0000 || puntos !== 16'd3) begin failures++; $display("FAIL catch_idle got=%b/%b/%0d exp=0/0000/3", captura, ocupados, puntos); end
  endtask

  task automatic test_saturation();
    pos_x_canasta = 10'd90; pos_y_canasta = 9'd0;
    do_reset();
    for (int k = 0; k < 4; k++) do_spawn(10'd100, 2'd3, 8'h01);
    do_tick();
    checks++; if (captura !== 1'b0) begin failures++; $display("FAIL sat_first got=%b exp=0", captura); end
    do_tick();
    checks++; if (captura !== 1'b1 || puntos !== 16'd12 || s_puntos !== 4'd12) begin failures++; $display("FAIL sat_four got=%b/%0d/%0d exp=1/12/12", captura, puntos, s_puntos); end
    step();
    do_spawn(10'd100, 2'd0, 8'h05);
    do_tick(); do_tick();
    checks++; if (puntos !== 16'd13 || s_puntos !== 4'd13) begin failures++; $display("FAIL sat_13 got=%0d/%0d exp=13/13", puntos, s_puntos); end
    step();
    do_spawn(10'd100, 2'd2, 8'hAA);
    do_spawn(10'd100, 2'd3, 8'hBB);
    probe(10'd100, 10'd0);
    checks++; if (pintar_obj !== 1'b1 || color_obj !== 8'hAA) begin failures++; $display("FAIL overlap got=%b/%h exp=1/aa", pintar_obj, color_obj); end
    do_tick(); do_tick();
    checks++; if (puntos !== 16'd18) begin failures++; $display("FAIL sum_two got=%0d exp=18", puntos); end
    checks++; if (s_puntos !== 4'hF || s_captura !== 1'b1) begin failures++; $display("FAIL saturate got=%h/%b exp=f/1", s_puntos, s_captura); end
    step();
    do_spawn(10'd100, 2'd1, 8'h77);
    do_tick();
    probe(10'd100, 10'd1);
    checks++; if (pintar_obj !== 1'b1 || ocupados !== 4'b0001) begin failures++; $display("FAIL pre_rst got=%b/%b exp=1/0001", pintar_obj, ocupados); end
    reset = 1'b1; pixel_x = 10'd100; pixel_y = 10'd1;
    step();
    reset = 1'b0; pixel_x = 10'd700; pixel_y = 10'd0;
    checks++; if ({pintar_obj, captura, perdido, spawn_ack, spawn_drop} !== 5'b0 || color_obj !== 8'h00) begin failures++; $display("FAIL midrst_flags got=%b/%h exp=0/00", {pintar_obj, captura, perdido, spawn_ack, spawn_drop}, color_obj); end
    checks++; if (puntos !== 16'd0 || ocupados !== 4'b0000 || s_puntos !== 4'd0) begin failures++; $display("FAIL midrst_state got=%0d/%b/%0d exp=0/0000/0", puntos, ocupados, s_puntos); end
  endtask

`ifdef PAUSA_EN
  task automatic test_pausa();
    pos_x_canasta = 10'd1000; pos_y_canasta = 9'd0;
    do_reset();
    do_spawn(10'd100, 2'd2, 8'h0F);
    do_tick(); do_tick();
    pausa = 1'b1;
    for (int k = 0; k < 5; k++) do_tick();
    probe(10'd100, 10'd4);
    checks++; if (pintar_obj !== 1'b1) begin failures++; $display("FAIL pausa_y4 got=%b exp=1", pintar_obj); end
    probe(10'd100, 10'd5);
    checks++; if (pintar_obj !== 1'b0) begin failures++; $display("FAIL pausa_y5 got=%b exp=0", pintar_obj); end
    do_spawn(10'd300, 2'd1, 8'hF0);
    checks++; if (spawn_ack !== 1'b1 || ocupados !== 4'b0011) begin failures++; $display("FAIL pausa_spawn got=%b/%b exp=1/0011", spawn_ack, ocupados); end
    pausa = 1'b0;
    do_tick();
    probe(10'd100, 10'd6);
    checks++; if (pintar_obj !== 1'b1) begin failures++; $display("FAIL pausa_resume got=%b exp=1", pintar_obj); end
    probe(10'd100, 10'd7);
    checks++; if (pintar_obj !== 1'b0) begin failures++; $display("FAIL pausa_resume_edge got=%b exp=0", pintar_obj); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    pixel_x = 10'd700; pixel_y = 10'd0;
    spawn = 1'b0; spawn_x = 10'd0; spawn_vel = 2'd0; spawn_color = 8'd0;
    pos_x_canasta = 10'd1000; pos_y_canasta = 9'd0;
`ifdef PAUSA_EN
    pausa = 1'b0;
`endif
    test_reset();
    test_basic();
    test_clamp();
    test_full_and_miss();
    test_catch();
    test_saturation();
`ifdef PAUSA_EN
    test_pausa();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
